// File: rtl/mem_bus_bridge.sv
// Bridges a single valid/ready request stream onto an ack-based SRAM-style bus, one transaction in flight.
// Optional bus watchdog enabled by defining MEM_BUS_BRIDGE_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_we,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      bus_cs,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH/8-1:0]   bus_be,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_ack,
  output logic                      timeout
);

  if (TIMEOUT < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
    $error("mem_bus_bridge: TIMEOUT must be >= 1 and DATA_WIDTH a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   accept_c;
  logic   abort_c;

  // A new request is taken while idle, or in the same cycle the pending response drains.
  assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
  assign accept_c  = req_valid && req_ready;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_inc;

  assign wd_cnt_inc = wd_cnt + CNT_W'(1);
  // An ack arriving on the final allowed cycle wins over the abort.
  assign abort_c    = (state == BUS) && !bus_ack && (wd_cnt_inc == CNT_W'(TIMEOUT));

  // Counter sits at zero outside BUS, so it is already clear on every BUS entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if ((state == BUS) && !bus_ack) begin
      wd_cnt <= wd_cnt_inc;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bus_cs     <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        BUS: begin
          if (bus_ack) begin
            resp_data  <= bus_we ? '0 : bus_rdata;
            resp_valid <= 1'b1;
            bus_cs     <= 1'b0;
            state      <= RESP;
          end else if (abort_c) begin
            resp_data  <= ERR_DATA;
            resp_valid <= 1'b1;
            bus_cs     <= 1'b0;
            timeout    <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: ;
      endcase
      // Request capture overrides the RESP->IDLE move for back-to-back transfers.
      if (accept_c) begin
        bus_cs    <= 1'b1;
        bus_we    <= req_we;
        bus_addr  <= req_addr;
        bus_be    <= req_be;
        bus_wdata <= req_wdata;
        state     <= BUS;
      end
    end
  end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Downstream stage of the prioritized memory arbiter: consumes the arbiter's single request stream and drives an external SRAM-style bus with ack-based wait states. It returns exactly one response per accepted request, writes included, so the arbiter's in-order ID queue stays balanced. One transaction is in flight at a time. An optional watchdog terminates bus cycles that never receive an ack.

## Interface
Parameters:
- ADDR_WIDTH, 32, request/bus address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- TIMEOUT, 255, cycles in BUS without ack before abort (watchdog builds only); must be ≥1
- ERR_DATA, 32'hDEADBEEF, response data returned on timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  decoupled.in  ADDR_WIDTH+1+DATA_WIDTH+DATA_WIDTH/8  fields {addr, we, wdata, be}; valid/ready handshake
- resp  decoupled.out  DATA_WIDTH  read data; 0 for writes; ERR_DATA on timeout
- bus_cs  out  1  bus cycle active
- bus_we  out  1  write strobe, qualified by bus_cs
- bus_addr  out  ADDR_WIDTH  address
- bus_be  out  DATA_WIDTH/8  byte enables
- bus_wdata  out  DATA_WIDTH  write data
- bus_rdata  in  DATA_WIDTH  read data, sampled with bus_ack
- bus_ack  in  1  cycle complete; sampled only while bus_cs=1
- timeout  out  1  one-cycle pulse when a bus cycle is aborted

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req.ready=1.
  - On req fire: latch addr/we/wdata/be into the bus output registers and go to BUS.
- BUS:
  - bus_cs=1; all bus outputs held stable.
  - On bus_ack=1 at a clock edge: capture bus_rdata (read) or 0 (write) into the response register, then go to RESP.
- RESP:
  - resp.valid=1; resp.data stable until resp fires.
  - req.ready=resp.ready, so a new request can be accepted in the same cycle the response fires.
  - On resp fire with req fire: latch the new request and go to BUS.
  - On resp fire alone: go to IDLE.
- req.ready is 0 in BUS. resp.valid is 0 in IDLE and BUS.
- bus_ack outside BUS is ignored; bus_rdata outside an acked BUS cycle is ignored.
- Outputs are registered; no combinational path from bus_ack to resp.valid or req.ready.

## Timing
- Reset values: state=IDLE; bus_cs=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0; resp.valid=0, resp.data=0; timeout=0; watchdog counter=0.
- Request fire at edge N → bus_cs=1 from cycle N+1.
- Ack sampled at edge M → bus_cs=0 and resp.valid=1 from cycle M+1.
- Minimum req-fire to resp.valid is 2 cycles (ack in the first BUS cycle).
- Back-to-back transactions: BUS is re-entered the cycle after the RESP handshake. Peak throughput is one transaction per 2 cycles plus wait states.
- Reset asserted mid-transaction: all state cleared immediately and bus_cs drops asynchronously. The in-flight request is discarded with no response; the arbiter is reset on the same net.
- rst deassertion: the first request can be accepted at the first edge with rst=1.

## Configuration
- Macro: MEM_BUS_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on BUS entry and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT with bus_ack=0, the bus cycle is aborted: next cycle bus_cs=0, state=RESP, resp.data=ERR_DATA, timeout=1 for one cycle.
  - An ack in the same cycle the count reaches TIMEOUT takes precedence (normal completion, no timeout pulse).
- Undefined: no counter; BUS waits indefinitely for ack; timeout is tied to 0; ERR_DATA and TIMEOUT are unused.

## Test plan
- Read, zero wait: req {addr=0x100, we=0} fires at edge 0; bus_ack=1 with bus_rdata=0x12345678 in cycle 1 → resp.valid=1 with data 0x12345678 in cycle 2; bus_cs is high only in cycle 1.
- Write with 3 wait states: req {addr=0x20, we=1, wdata=0xA5A5A5A5, be=4'b0011} → bus outputs stable for 4 cycles until ack; resp.data=0; exactly one response.
- Response backpressure plus back-to-back: resp.ready=0 for 5 cycles with the next req pending → req.ready=0 throughout; on the resp.ready edge both handshakes fire and bus_cs=1 next cycle with the new address.
- Stray ack: bus_ack=1 in IDLE and in RESP → no state change and no extra response.
- Timeout (macro on, TIMEOUT=4): no ack → abort after 4 BUS cycles; resp.data=0xDEADBEEF; timeout pulses for one cycle. Macro off: bus_cs stays high for 1000 cycles.
- Reset mid-BUS: drive rst=0 in the 2nd wait cycle → bus_cs=0 asynchronously and all outputs at reset values; after release, a new read completes normally.
